ahbl_slave_stage_ctrl: RTL and testbench



---
 rtl/ahbl_pkg.sv | 30 +++
 rtl/ahbl_stall_timer.sv | 46 ++++
 rtl/ahbl_slave_stage_ctrl.sv | 145 ++++++++++++++
 tb/tb_ahbl_slave_stage_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and helpers for the matrix stage controllers.
// Holds the HTRANS/HRESP codes, the stage FSM encoding and a one-hot decoder.
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DATA = 2'b01,
        ST_ERR1 = 2'b10,
        ST_ERR2 = 2'b11
    } stage_state_e;

    // OR of set-bit indices; exact for one-hot input, 0 for all-zero input.
    function automatic int unsigned onehot_to_idx(input logic [31:0] vec);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (vec[i]) idx = idx | unsigned'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ahbl_stall_timer.sv
// Saturating wait-state counter with terminal count at TIMEOUT_CYCLES-1.
// With TIMEOUT_CYCLES=0 the counter is removed and terminal count never fires.
module ahbl_stall_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        en_i,
    output logic [15:0] cnt_o,
    output logic        tc_o
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic timer_unused;
            assign timer_unused = ^{clk_i, rst_i, clr_i, en_i};
            assign cnt_o = '0;
            assign tc_o  = 1'b0;
        end else begin : g_on
            logic [15:0] cnt_q;
            logic [15:0] cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clr_i) begin
                    cnt_d = '0;
                end else if (en_i && (cnt_q != 16'hFFFF)) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cnt_o = cnt_q;
            assign tc_o  = (cnt_q == 16'(TIMEOUT_CYCLES - 1));
        end
    endgenerate

endmodule

// File: rtl/ahbl_slave_stage_ctrl.sv
// Per-slave stage controller: forwards the granted address phase, tracks the
// data-phase owner, and forces a two-cycle ERROR when the slave stalls too long.
module ahbl_slave_stage_ctrl
    import ahbl_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic [NUM_MASTERS-1:0]   MASTERADDRINPROG,
    input  logic [2*NUM_MASTERS-1:0] MHTRANS,
    input  logic                     HREADYOUT_S,
    input  logic                     HRESP_S,
    output logic                     HSEL_S,
    output logic [1:0]               HTRANS_S,
    output logic [NUM_MASTERS-1:0]   ADDRMUXSEL,
    output logic                     ADDRPHEND,
    output logic [NUM_MASTERS-1:0]   DATAMUXSEL,
    output logic                     HREADYOUT_M,
    output logic                     HRESP_M,
    output logic                     TIMEOUT_PULSE,
    output logic                     SLAVE_STUCK
);

    localparam int unsigned SW = $clog2(2 * NUM_MASTERS);

    stage_state_e           state_q, state_d;
    logic [NUM_MASTERS-1:0] owner_q, owner_d;
    logic                   stuck_q, stuck_d;
    logic                   pulse_q, pulse_d;

    logic [SW-1:0] gsel;
    logic [1:0]    gtrans;
    logic          any_grant;
    logic          fwd;
    logic          addr_ready;
    logic          acc;
    logic          phase_done;
    logic          waiting;
    logic [15:0]   wcnt;
    logic          wcnt_tc;

    assign any_grant = |MASTERADDRINPROG;
    assign gsel      = SW'(2 * onehot_to_idx(32'(MASTERADDRINPROG)));
    assign gtrans    = MHTRANS[gsel +: 2];

    // A stuck slave sees only idle address phases so its stale data phase drains.
    assign fwd        = any_grant & ~stuck_q;
    assign HSEL_S     = fwd;
    assign HTRANS_S   = fwd ? gtrans : HTRANS_IDLE;
    assign ADDRMUXSEL = fwd ? MASTERADDRINPROG : '0;

    assign waiting = (state_q == ST_DATA) & ~HREADYOUT_S;

    ahbl_stall_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_stall_timer (
        .clk_i (HCLK),
        .rst_i (HRESET),
        .clr_i (~waiting),
        .en_i  (waiting),
        .cnt_o (wcnt),
        .tc_o  (wcnt_tc)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        stuck_d     = stuck_q;
        pulse_d     = 1'b0;
        addr_ready  = 1'b1;
        HREADYOUT_M = 1'b1;
        HRESP_M     = HRESP_OKAY;
        phase_done  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                phase_done = 1'b1;
            end
            ST_DATA: begin
                addr_ready  = HREADYOUT_S;
                HREADYOUT_M = HREADYOUT_S;
                HRESP_M     = HRESP_S;
                phase_done  = HREADYOUT_S;
            end
            ST_ERR1: begin
                addr_ready  = 1'b0;
                HREADYOUT_M = 1'b0;
                HRESP_M     = HRESP_ERROR;
            end
            ST_ERR2: begin
                HRESP_M    = HRESP_ERROR;
                phase_done = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Address completion ignores HTRANS so IDLE transfers also retire.
        ADDRPHEND = any_grant & addr_ready;
        acc       = ADDRPHEND & gtrans[1];

        if (stuck_q && HREADYOUT_S) stuck_d = 1'b0;

        if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end else if (phase_done) begin
            if (acc) begin
                owner_d = MASTERADDRINPROG;
                state_d = stuck_q ? ST_ERR1 : ST_DATA;
            end else begin
                owner_d = '0;
                state_d = ST_IDLE;
            end
        end else if (wcnt_tc) begin
            state_d = ST_ERR1;
            stuck_d = 1'b1;
            pulse_d = 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            stuck_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            stuck_q <= stuck_d;
            pulse_q <= pulse_d;
        end
    end

    assign DATAMUXSEL    = owner_q;
    assign TIMEOUT_PULSE = pulse_q;
    assign SLAVE_STUCK   = stuck_q;

    logic wcnt_unused;
    assign wcnt_unused = ^wcnt;

endmodule

// File: tb/tb_ahbl_slave_stage_ctrl.sv
// Directed bench for ahbl_slave_stage_ctrl with NUM_MASTERS=4, TIMEOUT_CYCLES=8.
// Inputs change 1ns after each rising edge; outputs are checked 1ns later.
module tb_ahbl_slave_stage_ctrl;

    localparam int NM = 4;
    localparam int TO = 8;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic [NM-1:0] grant;
    logic [2*NM-1:0] mtrans;
    logic          rdy_s;
    logic          resp_s;
    logic          hsel_s;
    logic [1:0]    htrans_s;
    logic [NM-1:0] addrmuxsel;
    logic          addrphend;
    logic [NM-1:0] datamuxsel;
    logic          hready_m;
    logic          hresp_m;
    logic          to_pulse;
    logic          stuck;

    int errors = 0;
    int checks = 0;

    ahbl_slave_stage_ctrl #(
        .NUM_MASTERS    (NM),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .HCLK             (HCLK),
        .HRESET           (HRESET),
        .MASTERADDRINPROG (grant),
        .MHTRANS          (mtrans),
        .HREADYOUT_S      (rdy_s),
        .HRESP_S          (resp_s),
        .HSEL_S           (hsel_s),
        .HTRANS_S         (htrans_s),
        .ADDRMUXSEL       (addrmuxsel),
        .ADDRPHEND        (addrphend),
        .DATAMUXSEL       (datamuxsel),
        .HREADYOUT_M      (hready_m),
        .HRESP_M          (hresp_m),
        .TIMEOUT_PULSE    (to_pulse),
        .SLAVE_STUCK      (stuck)
    );

    // clock / reset
    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic [NM-1:0] g, input logic [2*NM-1:0] t,
                         input logic r, input logic e);
        grant  = g;
        mtrans = t;
        rdy_s  = r;
        resp_s = e;
        #1;
    endtask

    task automatic check_m(input string tag, input logic rdy, input logic resp,
                           input logic [NM-1:0] dsel);
        check_eq({tag, ".hready_m"}, 32'(hready_m), 32'(rdy));
        check_eq({tag, ".hresp_m"}, 32'(hresp_m), 32'(resp));
        check_eq({tag, ".datamuxsel"}, 32'(datamuxsel), 32'(dsel));
    endtask

    task automatic check_a(input string tag, input logic phend, input logic sel,
                           input logic [1:0] tr, input logic [NM-1:0] amux);
        check_eq({tag, ".addrphend"}, 32'(addrphend), 32'(phend));
        check_eq({tag, ".hsel_s"}, 32'(hsel_s), 32'(sel));
        check_eq({tag, ".htrans_s"}, 32'(htrans_s), 32'(tr));
        check_eq({tag, ".addrmuxsel"}, 32'(addrmuxsel), 32'(amux));
    endtask

    initial begin
        HRESET = 1'b1;
        grant = '0; mtrans = '0; rdy_s = 1'b1; resp_s = 1'b0;
        tick; tick;
        HRESET = 1'b0;

        // reset state
        drive(4'b0000, 8'h00, 1'b1, 1'b0);
        check_m("rst", 1'b1, 1'b0, 4'b0000);
        check_eq("rst.pulse", 32'(to_pulse), 0);
        check_eq("rst.stuck", 32'(stuck), 0);
        check_a("rst", 1'b0, 1'b0, 2'b00, 4'b0000);
        tick;

        // 1: single transfer from M0
        drive(4'b0001, 8'h02, 1'b1, 1'b0);
        check_a("t1.addr", 1'b1, 1'b1, 2'b10, 4'b0001);
        tick;
        drive(4'b0000, 8'h00, 1'b1, 1'b0);
        check_m("t1.data", 1'b1, 1'b0, 4'b0001);
        check_a("t1.data", 1'b0, 1'b0, 2'b00, 4'b0000);
        tick;
        // IDLE transfer retires its address phase but opens no data phase
        drive(4'b0100, 8'h00, 1'b1, 1'b0);
        check_m("t1.idle", 1'b1, 1'b0, 4'b0000);
        check_a("t1.idletr", 1'b1, 1'b1, 2'b00, 4'b0100);
        tick;
        // BUSY from M3 is forwarded but not accepted
        drive(4'b1000, 8'h40, 1'b1, 1'b0);
        check_m("t1.after_idletr", 1'b1, 1'b0, 4'b0000);
        check_a("t1.busy", 1'b1, 1'b1, 2'b01, 4'b1000);
        tick;
        drive(4'b0000, 8'h00, 1'b1, 1'b0);
        check_m("t1.after_busy", 1'b1, 1'b0, 4'b0000);
        tick;

        // 2: M0 then M2 pipelined, two wait states on M0
        drive(4'b0001, 8'h02, 1'b1, 1'b0);
        check_eq("t2.m0_phend", 32'(addrphend), 1);
        tick;
        for (int i = 0; i < 2; i++) begin
            drive(4'b0100, 8'h20, 1'b0, 1'b0);
            check_m("t2.wait", 1'b0, 1'b0, 4'b0001);
            check_a("t2.wait", 1'b0, 1'b1, 2'b10, 4'b0100);
            tick;
        end
        drive(4'b0100, 8'h20, 1'b1, 1'b0);
        check_m("t2.done", 1'b1, 1'b0, 4'b0001);
        check_eq("t2.m2_phend", 32'(addrphend), 1);
        tick;
        drive(4'b0000, 8'h00, 1'b1, 1'b0);
        check_m("t2.m2data", 1'b1, 1'b0, 4'b0100);
        tick;

        // 3: timeout after exactly 8 wait states
        drive(4'b0001, 8'h02, 1'b1, 1'b0);
        check_m("t3.idle", 1'b1, 1'b0, 4'b0000);
        tick;
        for (int i = 0; i < TO; i++) begin
            drive(4'b0000, 8'h00, 1'b0, 1'b0);
            check_m($sformatf("t3.wait%0d", i), 1'b0, 1'b0, 4'b0001);
            check_eq("t3.wait.pulse", 32'(to_pulse), 0);
            tick;
        end
        drive(4'b0000, 8'h00, 1'b0, 1'b0);
        check_m("t3.err1", 1'b0, 1'b1, 4'b0001);
        check_eq("t3.err1.pulse", 32'(to_pulse), 1);
        check_eq("t3.err1.stuck", 32'(stuck), 1);
        tick;
        drive(4'b0000, 8'h00, 1'b0, 1'b0);
        check_m("t3.err2", 1'b1, 1'b1, 4'b0001);
        check_eq("t3.err2.pulse", 32'(to_pulse), 0);
        tick;

        // 4: access while stuck, then recovery
        drive(4'b0010, 8'h08, 1'b0, 1'b0);
        check_eq("t4.stuck", 32'(stuck), 1);
        check_m("t4.idle", 1'b1, 1'b0, 4'b0000);
        check_a("t4.blocked", 1'b1, 1'b0, 2'b00, 4'b0000);
        tick;
        drive(4'b0010, 8'h08, 1'b0, 1'b0);
        check_m("t4.err1", 1'b0, 1'b1, 4'b0010);
        check_eq("t4.err1.pulse", 32'(to_pulse), 0);
        check_eq("t4.err1.phend", 32'(addrphend), 0);
        tick;
        drive(4'b0010, 8'h00, 1'b0, 1'b0);
        check_m("t4.err2", 1'b1, 1'b1, 4'b0010);
        check_eq("t4.err2.phend", 32'(addrphend), 1);
        tick;
        drive(4'b0000, 8'h00, 1'b1, 1'b0);
        check_eq("t4.still_stuck", 32'(stuck), 1);
        check_m("t4.idle2", 1'b1, 1'b0, 4'b0000);
        tick;
        drive(4'b0010, 8'h08, 1'b1, 1'b0);
        check_eq("t4.recovered", 32'(stuck), 0);
        check_a("t4.fwd", 1'b1, 1'b1, 2'b10, 4'b0010);
        tick;
        drive(4'b0000, 8'h00, 1'b0, 1'b1);
        check_m("t4.slverr1", 1'b0, 1'b1, 4'b0010);
        tick;
        drive(4'b0000, 8'h00, 1'b1, 1'b1);
        check_m("t4.slverr2", 1'b1, 1'b1, 4'b0010);
        tick;
        drive(4'b0000, 8'h00, 1'b1, 1'b0);
        check_m("t4.end", 1'b1, 1'b0, 4'b0000);
        tick;

        // 5: slave ready at wcnt=7 beats the timeout
        drive(4'b0001, 8'h02, 1'b1, 1'b0);
        tick;
        for (int i = 0; i < TO - 1; i++) begin
            drive(4'b0000, 8'h00, 1'b0, 1'b0);
            check_eq("t5.wait", 32'(hready_m), 0);
            tick;
        end
        drive(4'b0000, 8'h00, 1'b1, 1'b0);
        check_m("t5.race", 1'b1, 1'b0, 4'b0001);
        tick;
        drive(4'b0000, 8'h00, 1'b1, 1'b0);
        check_m("t5.after", 1'b1, 1'b0, 4'b0000);
        check_eq("t5.pulse", 32'(to_pulse), 0);
        check_eq("t5.stuck", 32'(stuck), 0);
        tick;

        // 6: reset in the third wait cycle abandons the transfer
        drive(4'b0001, 8'h02, 1'b1, 1'b0);
        tick;
        for (int i = 0; i < 2; i++) begin
            drive(4'b0000, 8'h00, 1'b0, 1'b0);
            tick;
        end
        drive(4'b0000, 8'h00, 1'b0, 1'b0);
        HRESET = 1'b1;
        tick;
        HRESET = 1'b0;
        drive(4'b0000, 8'h00, 1'b0, 1'b0);
        check_m("t6.rst", 1'b1, 1'b0, 4'b0000);
        check_eq("t6.stuck", 32'(stuck), 0);
        check_eq("t6.pulse", 32'(to_pulse), 0);
        tick;
        // a fresh transfer must again see a full 8 wait states
        drive(4'b0001, 8'h02, 1'b1, 1'b0);
        tick;
        for (int i = 0; i < TO; i++) begin
            drive(4'b0000, 8'h00, 1'b0, 1'b0);
            check_m("t6.wait", 1'b0, 1'b0, 4'b0001);
            tick;
        end
        drive(4'b0000, 8'h00, 1'b0, 1'b0);
        check_eq("t6.err1.pulse", 32'(to_pulse), 1);
        tick;
        drive(4'b0000, 8'h00, 1'b1, 1'b0);
        check_m("t6.err2", 1'b1, 1'b1, 4'b0001);
        tick;
        drive(4'b0000, 8'h00, 1'b1, 1'b0);
        check_eq("t6.clear", 32'(stuck), 0);
        check_m("t6.idle", 1'b1, 1'b0, 4'b0000);
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
